// File: rtl/boot_ctrl_pkg.sv
// rtl/boot_ctrl_pkg.sv - shared state encoding and word geometry for boot_ctrl
package boot_ctrl_pkg;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WORD_W = 32;

  // Big-endian placement: lane 0 lands in the top byte of the word.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return 5'(WORD_W - 8) - {lane, 3'b000};
  endfunction

endpackage

// File: rtl/boot_ctrl_word_pack.sv
// rtl/boot_ctrl_word_pack.sv - packs loader bytes into big-endian instruction words
module word_pack
  import boot_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              valid,
  input  logic              last,
  input  logic              clear,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [1:0]        lane
);

  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] merged;

  always_comb begin
    merged = acc | (WORD_W'(byte_in) << lane_shift(lane));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      lane       <= 2'd0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      lane       <= 2'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (valid) begin
        // A final byte flushes the partial word; unfilled low lanes stay zero.
        if (lane == 2'd3 || last) begin
          word       <= merged;
          word_valid <= 1'b1;
          acc        <= '0;
          lane       <= 2'd0;
        end else begin
          acc  <= merged;
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/boot_ctrl.sv
// rtl/boot_ctrl.sv - boot loader FSM: stream image into imem, release core, count cycles
// Optional watchdog enabled by defining BOOT_WATCHDOG_EN.
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] WDOG_LIMIT = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  input  logic        core_finish,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        timeout,
  output logic [31:0] cycles
);

  localparam logic [29:0] MAX_WORDS = 30'(IMEM_WORDS);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              pend;
  logic [29:0]       word_index;
  logic [WORD_W-1:0] pk_word;
  logic              pk_valid;
  logic [1:0]        pk_lane;
  logic              accept;
  logic              restart_ok;
  logic              room;
  logic              unused_lane;

  // pend marks the cycle the final word is written; no bytes are taken then.
  assign in_ready   = rst_n & (state == ST_LOAD) & ~pend;
  assign accept     = in_valid & in_ready;
  assign restart_ok = restart & (state == ST_DONE);
  assign room       = (word_index < MAX_WORDS);
  assign unused_lane = ^pk_lane;

  word_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (in_data),
    .valid      (accept),
    .last       (in_last),
    .clear      (restart_ok),
    .word       (pk_word),
    .word_valid (pk_valid),
    .lane       (pk_lane)
  );

  assign imem_we    = pk_valid & room;
  assign imem_addr  = {word_index, 2'b00};
  assign imem_wdata = pk_word;
  assign busy       = (state == ST_LOAD) || (state == ST_RUN);
  assign done       = (state == ST_DONE);

`ifdef BOOT_WATCHDOG_EN
  logic wd_hit;
  logic timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
`ifdef BOOT_WATCHDOG_EN
    wd_hit = 1'b0;
`endif
    case (state)
      ST_LOAD: if (pend) state_nxt = ST_RUN;
      ST_RUN: begin
        if (core_finish) begin
          state_nxt = ST_DONE;
`ifdef BOOT_WATCHDOG_EN
        end else if (cycles == WDOG_LIMIT - 32'd1) begin
          state_nxt = ST_DONE;
          wd_hit    = 1'b1;
`endif
        end
      end
      ST_DONE: if (restart) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      pend       <= 1'b0;
      word_index <= '0;
      cycles     <= '0;
      ovf        <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      state      <= state_nxt;
      core_rst_n <= (state_nxt != ST_LOAD);
      pend       <= accept & in_last;
      if (restart_ok) begin
        word_index <= '0;
        cycles     <= '0;
        ovf        <= 1'b0;
      end else begin
        if (imem_we) word_index <= word_index + 30'd1;
        if (pk_valid && !room) ovf <= 1'b1;
        if (state == ST_RUN) cycles <= cycles + 32'd1;
      end
    end
  end

`ifdef BOOT_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          timeout_q <= 1'b0;
    else if (restart_ok) timeout_q <= 1'b0;
    else if (wd_hit)     timeout_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_boot_ctrl.sv
// tb/tb_boot_ctrl.sv - randomized self-checking bench for boot_ctrl
module tb_boot_ctrl;

  localparam int          IMEM_WORDS = 2;
  localparam logic [31:0] WDOG_LIMIT = 32'd16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        core_finish = 1'b0;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        timeout;
  logic [31:0] cycles;

  always #5 clk = ~clk;

  boot_ctrl #(.IMEM_WORDS(IMEM_WORDS), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .restart(restart),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .core_finish(core_finish), .busy(busy),
    .done(done), .ovf(ovf), .timeout(timeout), .cycles(cycles)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  img[$];
  logic [63:0] wr_seen[$];
  logic        exp_ovf;

  always @(negedge clk) if (imem_we) wr_seen.push_back({imem_addr, imem_wdata});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_cycles", cycles, 0);
    check("rst_ovf", ovf, 0);
    check("rst_timeout", timeout, 0);
    check("rst_done", done, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_busy", busy, 1);
  endtask

  // Called from a negedge; drops rst_n between clock edges.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_ready", in_ready, 1);
    @(negedge clk);
  endtask

  // Streams img, then checks the hand-off to RUN and the resulting imem writes.
  task automatic load_image(input int max_gap);
    int nw;
    int ew;
    int gap;
    logic [31:0] exp;
    wr_seen.delete();
    foreach (img[i]) begin
      gap = $urandom_range(max_gap, 0);
      repeat (gap) @(negedge clk);
      check("load_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = img[i];
      in_last  = (i == img.size() - 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    check("pend_ready", in_ready, 0);
    check("pend_core_rst", core_rst_n, 0);
    @(negedge clk);
    check("run_core_rst", core_rst_n, 1);
    check("run_busy", busy, 1);
    check("run_ready", in_ready, 0);
    check("run_cycles0", cycles, 0);
    nw = (img.size() + 3) / 4;
    ew = (nw < IMEM_WORDS) ? nw : IMEM_WORDS;
    exp_ovf = (nw > IMEM_WORDS);
    check("wr_count", wr_seen.size(), ew);
    for (int w = 0; w < ew && w < wr_seen.size(); w++) begin
      exp = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < img.size()) exp[31 - 8 * b -: 8] = img[4 * w + b];
      check("wr_addr", wr_seen[w][63:32], 32'(4 * w));
      check("wr_data", wr_seen[w][31:0], exp);
    end
    check("ovf", ovf, exp_ovf);
  endtask

  // Starts at the negedge of RUN cycle 1; finish is raised during cycle k.
  task automatic run_finish(input int k, input bit poke_restart);
    for (int c = 1; c < k; c++) begin
      if (poke_restart && c == 1) restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      if (poke_restart && c == 1) begin
        check("restart_ignored_busy", busy, 1);
        check("restart_ignored_core", core_rst_n, 1);
      end
    end
    core_finish = 1'b1;
    @(negedge clk);
    core_finish = 1'b0;
    check("done", done, 1);
    check("done_cycles", cycles, 32'(k));
    check("done_busy", busy, 0);
    check("done_core_rst", core_rst_n, 1);
    check("done_timeout", timeout, 0);
    core_finish = 1'b1;
    repeat (3) @(negedge clk);
    core_finish = 1'b0;
    check("hold_done", done, 1);
    check("hold_cycles", cycles, 32'(k));
    check("hold_ovf", ovf, exp_ovf);
    check("hold_ready", in_ready, 0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_busy", busy, 1);
    check("rs_done", done, 0);
    check("rs_cycles", cycles, 0);
    check("rs_ovf", ovf, 0);
    check("rs_timeout", timeout, 0);
    check("rs_core_rst", core_rst_n, 0);
    check("rs_ready", in_ready, 1);
  endtask

  initial begin
    int n;
    int waited;
    #1 check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", in_ready, 1);
    core_finish = 1'b1;
    @(negedge clk);
    core_finish = 1'b0;
    check("finish_ignored_load", busy, 1);
    check("finish_ignored_ready", in_ready, 1);

    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h10, 8'h00, 8'hFF, 8'hFF};
    load_image(0);
    run_finish(10, 1'b0);
    do_restart();

    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load_image(1);
    run_finish(3, 1'b1);
    do_restart();

    img.delete();
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
    load_image(0);
    run_finish(2, 1'b0);
    do_restart();

    for (int it = 0; it < 8; it++) begin
      img.delete();
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      load_image(2);
      run_finish($urandom_range(12, 2), 1'($urandom_range(1, 0)));
      do_restart();
    end

    img = '{8'h01, 8'h02, 8'h03};
    load_image(0);
`ifdef BOOT_WATCHDOG_EN
    waited = 0;
    while (!done && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("wd_done", done, 1);
    check("wd_cycles", cycles, 16);
    check("wd_timeout", timeout, 1);
    do_restart();
    load_image(0);
    run_finish(16, 1'b0);
`else
    waited = 0;
    run_finish(30, 1'b0);
`endif
    do_restart();

    img = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    load_image(0);
    repeat (3) @(negedge clk);
    async_reset();

    in_valid = 1'b1;
    in_data  = 8'hDE;
    @(negedge clk);
    in_data  = 8'hAD;
    @(negedge clk);
    in_valid = 1'b0;
    async_reset();
    img = '{8'h12, 8'h34, 8'h56, 8'h78};
    load_image(0);
    run_finish(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
